// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: control-flow op codes,
// sequencer states and the default address width.
package pc_seq_pkg;

    localparam int unsigned DefaultAw = 7;

    typedef enum logic [2:0] {
        OpSeq  = 3'd0,
        OpBr   = 3'd1,
        OpJmp  = 3'd2,
        OpCall = 3'd3,
        OpRet  = 3'd4,
        OpHalt = 3'd5
    } ctl_op_e;

    typedef enum logic {
        StRun,
        StHalt
    } state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: small LIFO with a 0..DEPTH pointer. A push while full or
// a pop while empty is ignored here; the caller flags those cases.
module pc_ras #(
    parameter int unsigned AW    = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] top_ptr;

    assign full    = (ptr_q == PW'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign top_ptr = ptr_q - PW'(1);
    assign top     = mem_q[top_ptr[IW-1:0]];

    always_comb begin
        ptr_d = ptr_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[ptr_q[IW-1:0]] = data;
            ptr_d                = ptr_q + PW'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    // Entry contents are left alone on reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter: sequential, branch, jump,
// call/return through a return-address stack, stall and halt/resume.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned   AW        = DefaultAw,
    parameter int unsigned   RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC  = AW'(1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cur_pc,
    input  logic [2:0]    ctl_op,
    input  logic          br_taken,
    input  logic [AW-1:0] target,
    input  logic          stall,
    input  logic          resume,
    output logic [AW-1:0] next_pc,
    output logic          halted,
    output logic          ras_ovf,
    output logic          ras_unf
);

    state_e        state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ras_push, ras_pop;
    logic          ras_full, ras_empty;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] pc_inc;
    ctl_op_e       op;

    assign op     = ctl_op_e'(ctl_op);
    assign pc_inc = cur_pc + AW'(1);

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .data  (pc_inc),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_comb begin
        state_d  = state_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        next_pc  = cur_pc;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (state_q == StHalt) begin
            if (resume && !stall) begin
                next_pc = pc_inc;
                state_d = StRun;
            end
        end else if (!stall) begin
            case (op)
                // Same-width add wraps, so the offset behaves as sign-extended.
                OpBr:    next_pc = br_taken ? pc_inc + target : pc_inc;
                OpJmp:   next_pc = target;
                OpCall: begin
                    next_pc = target;
                    if (ras_full) ovf_d = 1'b1;
                    else          ras_push = 1'b1;
                end
                OpRet: begin
                    if (ras_empty) begin
                        next_pc = pc_inc;
                        unf_d   = 1'b1;
                    end else begin
                        next_pc = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                OpHalt:  state_d = StHalt;
                default: next_pc = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign halted  = (state_q == StHalt);
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-address controller for the single-cycle core's program counter. Each cycle it takes the current PC and the decoded control-flow operation, and produces the value the PC register loads on the next clock. It handles sequential, branch, jump, call/return (4-deep return-address stack), stall and halt/resume. Its `next_pc` output drives the PC register's next-address input; the PC register's address output feeds back as `cur_pc`.

## Interface
Parameters:
- `AW`, 7, address width (matches PC register)
- `RAS_DEPTH`, 4, return-address stack entries
- `RESET_PC`, 7'd1, value presented on `next_pc` while reset is high (matches PC reset value)

Ports:
- `clk` in 1: single clock, all state updates on posedge
- `reset` in 1: synchronous, active-high; highest priority
- `cur_pc` in AW: current PC (PC register output)
- `ctl_op` in 3: control-flow op (SEQ, BR, JMP, CALL, RET, HALT; other codes act as SEQ)
- `br_taken` in 1: branch condition from ALU, used only with BR
- `target` in AW: JMP/CALL absolute target; BR signed two's-complement offset
- `stall` in 1: hold PC this cycle
- `resume` in 1: leave HALT
- `next_pc` out AW: next PC value, combinational
- `halted` out 1: registered, high in HALT state
- `ras_ovf` out 1: sticky, push attempted on full stack
- `ras_unf` out 1: sticky, pop attempted on empty stack

## Operation
- **States:**
  - RUN: reset state.
  - HALT.
- **`next_pc` priority, highest first:**
  1. `reset`: `RESET_PC`.
  2. HALT state: `cur_pc`. If `resume` and not `stall`, the value is `cur_pc+1` instead, and the state moves to RUN at the clock edge.
  3. RUN with `stall`: `cur_pc`. `ctl_op` is ignored; no stack or flag change.
  4. RUN with no stall, by `ctl_op`:
     - SEQ: `cur_pc+1`.
     - BR: `cur_pc+1+target` if `br_taken`, else `cur_pc+1`.
     - JMP: `target`.
     - CALL: push `cur_pc+1`; result is `target`. If the stack is full, the push is dropped, `ras_ovf` is set, and the jump is still taken.
     - RET: pop; result is the old top. If the stack is empty, the result is `cur_pc+1`, `ras_unf` is set, and the pointer is unchanged.
     - HALT: `cur_pc`; state moves to HALT.
- **Arithmetic:** all modulo 2^AW.
  - 127+1 = 0.
  - BR offset is sign-extended: `target`=7'h7E means −2.
- `resume` in RUN is ignored.
- `br_taken` is ignored except for BR.
- **Stack:** LIFO; pointer 0..`RAS_DEPTH`. Full when pointer equals `RAS_DEPTH`, empty when it is 0. Only CALL and RET touch it.
- **Sticky flags:** `ras_ovf` and `ras_unf` clear only on reset.
- **Reset mid-operation:** state becomes RUN, stack pointer 0, `halted` 0, flags 0. Stack entry contents need not be cleared.

## Timing
- `next_pc` is purely combinational from `cur_pc`, `ctl_op`, `br_taken`, `target`, `stall`, `resume`, state and stack top. It settles within the same cycle.
- Zero-cycle latency: the op presented in cycle N determines the PC in cycle N+1.
- Stack pointer, stack entries, state, `halted` and the flags update at the posedge that ends the cycle in which the op is presented.
- A RET in the cycle immediately after a CALL returns the address pushed by that CALL.
- `halted` rises one cycle after the HALT op and falls one cycle after an accepted resume.
- Reset values:
  - `halted` = 0
  - `ras_ovf` = 0
  - `ras_unf` = 0
  - `next_pc` = `RESET_PC` while `reset` is high

## Structure
- **Shared package `pc_seq_pkg`:**
  - `ctl_op` encodings: SEQ=0, BR=1, JMP=2, CALL=3, RET=4, HALT=5.
  - State enum: RUN, HALT.
  - Default `AW`.
- **Sub-module `pc_ras`:** parameterised LIFO.
  - Inputs: push, pop, data.
  - Outputs: top, full, empty.
  - Push and pop never occur in the same cycle.
- **Top level:** state register, next-PC mux, overflow/underflow logic.
- **Bench:** instantiate with the PC register closing the loop.

## Test plan
- Release reset with `ctl_op`=SEQ for 3 cycles -> PC sequence 1, 2, 3, 4; `halted`=0, both flags 0.
- PC=5, BR with `target`=7'h7E (−2), `br_taken`=1 -> PC=4. Repeat with `br_taken`=0 -> PC=6. PC=127, SEQ -> PC=0.
- PC=10, CALL `target`=40; then at 40, RET -> PC=40 then 11. Nested 4 CALLs then 4 RETs return in LIFO order. A 5th CALL sets `ras_ovf` and still jumps.
- RET on empty stack at PC=20 -> PC=21, `ras_unf`=1, stays 1 until reset.
- PC=8, HALT -> PC holds 8 and `halted`=1 next cycle. `resume` with `stall`=1 -> still 8. `resume` with `stall`=0 -> PC=9, `halted`=0.
- Stall during CALL at PC=30 for 2 cycles -> PC stays 30, stack pointer unchanged. Assert `reset` while halted with 2 stack entries -> `next_pc`=1, `halted`=0, stack empty (subsequent RET sets `ras_unf`).
